fetch_buffered: RTL and testbench



---
 rtl/fetch_buffered_if.sv | 41 ++++
 rtl/fetch_buffered.sv | 92 +++++++++
 tb/tb_fetch_buffered.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffered_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect and decode handshake.
// Performance counter outputs exist only when FETCH_BUFFERED_PERF_EN is defined.
interface fetch_buffered_if #(
    parameter int INS_SIZE = 32,
    parameter int PC_NUM   = 256,
    parameter int DEPTH    = 4
);
    localparam int PC_W  = $clog2(PC_NUM);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                imem_req_o;
    logic [PC_W-1:0]     imem_addr_o;
    logic [INS_SIZE-1:0] imem_data_i;
    logic                redirect_i;
    logic [PC_W-1:0]     redirect_pc_i;
    logic                fetch_valid_o;
    logic                fetch_ready_i;
    logic [INS_SIZE-1:0] fetch_inst_o;
    logic [PC_W-1:0]     fetch_pc_o;
    logic [CNT_W-1:0]    fetch_count_o;
`ifdef FETCH_BUFFERED_PERF_EN
    logic [31:0]         perf_stall_cycles_o;
    logic [31:0]         perf_redirects_o;
`endif

    modport master (
        output imem_req_o, imem_addr_o, fetch_valid_o, fetch_inst_o, fetch_pc_o, fetch_count_o,
`ifdef FETCH_BUFFERED_PERF_EN
        output perf_stall_cycles_o, perf_redirects_o,
`endif
        input  imem_data_i, redirect_i, redirect_pc_i, fetch_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, fetch_valid_o, fetch_inst_o, fetch_pc_o, fetch_count_o,
`ifdef FETCH_BUFFERED_PERF_EN
        input  perf_stall_cycles_o, perf_redirects_o,
`endif
        output imem_data_i, redirect_i, redirect_pc_i, fetch_ready_i
    );
endinterface

// File: rtl/fetch_buffered.sv
// Buffered fetch stage: PC generator, 1-cycle imem port, DEPTH-entry prefetch FIFO to decode.
// Optional stall/redirect counters enabled by FETCH_BUFFERED_PERF_EN.
module fetch_buffered #(
    parameter int INS_SIZE = 32,
    parameter int PC_NUM   = 256,
    parameter int DEPTH    = 4
) (
    input logic             clk,
    input logic             srst,
    fetch_buffered_if.master bus
);
    localparam int PC_W  = $clog2(PC_NUM);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]     pc_q, infl_pc_q, pc_next, redir_target;
    logic                inflight_q;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q, credit_used;
    logic [INS_SIZE-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]     mem_pc   [DEPTH];
    logic                issue, push, pop, valid;

    always_comb begin
        credit_used  = count_q + CNT_W'(inflight_q);
        issue        = !srst && !bus.redirect_i && (credit_used < CNT_W'(DEPTH));
        valid        = (count_q != '0);
        // A redirect drops the response arriving this cycle; nothing issues during a redirect.
        push         = inflight_q && !bus.redirect_i;
        pop          = valid && bus.fetch_ready_i;
        pc_next      = (pc_q == PC_W'(PC_NUM - 1)) ? '0 : pc_q + 1'b1;
        redir_target = ({1'b0, bus.redirect_pc_i} >= (PC_W + 1)'(PC_NUM)) ? '0 : bus.redirect_pc_i;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                infl_pc_q <= pc_q;
                pc_q      <= pc_next;
            end
            if (bus.redirect_i) begin
                pc_q    <= redir_target;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && push) begin
            mem_inst[tail_q] <= bus.imem_data_i;
            mem_pc[tail_q]   <= infl_pc_q;
        end
    end

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = pc_q;
    assign bus.fetch_valid_o = valid;
    assign bus.fetch_inst_o  = valid ? mem_inst[head_q] : '0;
    assign bus.fetch_pc_o    = valid ? mem_pc[head_q] : '0;
    assign bus.fetch_count_o = count_q;

`ifdef FETCH_BUFFERED_PERF_EN
    logic [31:0] stall_q, redir_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (valid && !bus.fetch_ready_i && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (bus.redirect_i && redir_q != '1)              redir_q <= redir_q + 1'b1;
        end
    end

    assign bus.perf_stall_cycles_o = stall_q;
    assign bus.perf_redirects_o    = redir_q;
`endif
endmodule

// File: tb/tb_fetch_buffered.sv
// Randomised + directed bench for fetch_buffered against a queue-based model of the fetch rules.
module tb_fetch_buffered;
    localparam int INS = 32;
    localparam int PCN = 10;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    fetch_buffered_if #(.INS_SIZE(INS), .PC_NUM(PCN), .DEPTH(DEP)) bus();
    fetch_buffered #(.INS_SIZE(INS), .PC_NUM(PCN), .DEPTH(DEP)) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    int vectors = 0;
    int fails   = 0;

    logic [31:0] q_inst[$];
    int          q_pc[$];
    int          acc_pc[$];
    int          m_pc = 0;
    bit          m_infl = 0;
    int          m_infl_pc = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_redir = 0;

    bit          e_req, e_valid;
    bit          c_s, c_r, c_rd;
    int          c_rp;
    logic [31:0] c_data;

    function automatic logic [31:0] rom(int a);
        return 32'h100 + 32'(a);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and compare all outputs against the model.
    task automatic cyc(input bit s, input bit r, input int rp, input bit rd);
        logic [31:0] exp_inst;
        int          exp_pc;
        c_s = s; c_r = r; c_rp = rp; c_rd = rd;
        c_data = m_infl ? rom(m_infl_pc) : 32'($urandom);
        srst              = s;
        bus.redirect_i    = r;
        bus.redirect_pc_i = 4'(rp);
        bus.fetch_ready_i = rd;
        bus.imem_data_i   = c_data;
        #2;
        e_req   = !s && !r && (q_pc.size() + int'(m_infl) < DEP);
        e_valid = (q_pc.size() != 0);
        exp_inst = '0;
        exp_pc   = 0;
        if (e_valid) begin
            exp_inst = q_inst[0];
            exp_pc   = q_pc[0];
        end
        chk("imem_req", 32'(bus.imem_req_o), 32'(e_req));
        if (e_req) chk("imem_addr", 32'(bus.imem_addr_o), 32'(m_pc));
        chk("fetch_valid", 32'(bus.fetch_valid_o), 32'(e_valid));
        chk("fetch_count", 32'(bus.fetch_count_o), 32'(q_pc.size()));
        chk("fetch_inst", bus.fetch_inst_o, exp_inst);
        chk("fetch_pc", 32'(bus.fetch_pc_o), 32'(exp_pc));
`ifdef FETCH_BUFFERED_PERF_EN
        chk("perf_stall", bus.perf_stall_cycles_o, m_stall);
        chk("perf_redir", bus.perf_redirects_o, m_redir);
`endif
    endtask

    // Apply the clock edge to the model, then advance the DUT.
    task automatic adv();
        if (c_s) begin
            q_inst.delete(); q_pc.delete();
            m_pc = 0; m_infl = 0; m_stall = 0; m_redir = 0;
        end else begin
            if (e_valid && !c_rd && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (c_r && m_redir != 32'hFFFF_FFFF) m_redir++;
            if (e_valid && c_rd) begin
                acc_pc.push_back(q_pc[0]);
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (m_infl && !c_r) begin
                q_inst.push_back(c_data);
                q_pc.push_back(m_infl_pc);
            end
            if (c_r) begin
                q_inst.delete(); q_pc.delete();
                m_pc = (c_rp >= PCN) ? 0 : c_rp;
            end
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = m_pc;
                m_pc = (m_pc + 1) % PCN;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input bit s, input bit r, input int rp, input bit rd);
        cyc(s, r, rp, rd);
        adv();
    endtask

    initial begin
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.fetch_ready_i = 1'b0;
        bus.imem_data_i   = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset release with ready=1: stream and wrap 9 -> 0.
        step(1, 0, 0, 1);
        acc_pc.delete();
        cyc(0, 0, 0, 1);
        chk("rst_count", 32'(bus.fetch_count_o), 0);
        chk("rst_valid", 32'(bus.fetch_valid_o), 0);
        chk("first_req", 32'(bus.imem_req_o), 1);
        chk("first_addr", 32'(bus.imem_addr_o), 0);
        adv();
        cyc(0, 0, 0, 1);
        chk("c1_addr", 32'(bus.imem_addr_o), 1);
        chk("c1_valid", 32'(bus.fetch_valid_o), 0);
        adv();
        cyc(0, 0, 0, 1);
        chk("first_valid", 32'(bus.fetch_valid_o), 1);
        chk("first_inst", bus.fetch_inst_o, 32'h100);
        chk("first_pc", 32'(bus.fetch_pc_o), 0);
        adv();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        chk("wrap_n", 32'(acc_pc.size() >= 12), 1);
        for (int k = 0; k < 12 && k < acc_pc.size(); k++) chk("wrap_seq", 32'(acc_pc[k]), 32'(k % PCN));

        // Back-pressure fills exactly DEPTH entries, then drains in order.
        step(1, 0, 0, 0);
        acc_pc.delete();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("full_count", 32'(bus.fetch_count_o), 4);
        chk("full_noreq", 32'(bus.imem_req_o), 0);
        chk("full_head", 32'(bus.fetch_pc_o), 0);
        adv();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        for (int k = 0; k < 4 && k < acc_pc.size(); k++) chk("drain_seq", 32'(acc_pc[k]), 32'(k));
        chk("drain_n", 32'(acc_pc.size() >= 4), 1);

        // Redirect to 5 with 3 entries buffered and a read in flight.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        cyc(0, 1, 5, 0);
        chk("pre_redir_count", 32'(bus.fetch_count_o), 3);
        adv();
        cyc(0, 0, 0, 0);
        chk("redir_count", 32'(bus.fetch_count_o), 0);
        chk("redir_valid", 32'(bus.fetch_valid_o), 0);
        chk("redir_req", 32'(bus.imem_req_o), 1);
        chk("redir_addr", 32'(bus.imem_addr_o), 5);
        adv();
        step(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("redir_first_pc", 32'(bus.fetch_pc_o), 5);
        chk("redir_first_inst", bus.fetch_inst_o, 32'h105);
        adv();

        // Out-of-range redirect target restarts at 0.
        cyc(0, 1, PCN + 3, 1);
        adv();
        cyc(0, 0, 0, 1);
        chk("clamp_addr", 32'(bus.imem_addr_o), 0);
        adv();
        step(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("clamp_pc", 32'(bus.fetch_pc_o), 0);
        chk("clamp_inst", bus.fetch_inst_o, 32'h100);
        adv();

        // Mid-stream reset with a read in flight.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("srst_valid", 32'(bus.fetch_valid_o), 0);
        chk("srst_count", 32'(bus.fetch_count_o), 0);
        chk("srst_inst", bus.fetch_inst_o, 0);
        chk("srst_pc", 32'(bus.fetch_pc_o), 0);
        chk("srst_addr", 32'(bus.imem_addr_o), 0);
`ifdef FETCH_BUFFERED_PERF_EN
        chk("srst_perf_stall", bus.perf_stall_cycles_o, 0);
        chk("srst_perf_redir", bus.perf_redirects_o, 0);
`endif
        adv();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 int'($urandom_range(15)), bit'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
